// File: rtl/arcino_data_mem_responder.sv
// Data-bus responder (req/gnt/rvalid) backed by a word-wide, byte-enabled RAM.
// Grant waits WAIT_STATES cycles of held req (frozen by stall_i); response follows grant by one cycle.
module arcino_data_mem_responder #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  input  logic        stall_i,
  output logic        busy_o
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  logic [31:0]      mem [NUM_WORDS];
  logic [3:0]       cnt;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [32:0]      addr_ext;
  logic [32:0]      base_ext;
  logic [32:0]      limit_ext;
  logic [32:0]      addr_off;
  logic             in_range;
  logic [IDX_W-1:0] index;
  logic             gnt;
  logic             unused_bits;

  // 33-bit compare keeps addresses near 2^32 from wrapping into range.
  assign addr_ext  = {1'b0, data_addr_i};
  assign base_ext  = {1'b0, BASE_ADDR};
  assign limit_ext = base_ext + (33'(NUM_WORDS) << 2);
  assign addr_off  = addr_ext - base_ext;
  assign in_range  = (addr_ext >= base_ext) && (addr_ext < limit_ext);
  assign index     = addr_off[IDX_W+1:2];
  assign unused_bits = ^{addr_off[32:IDX_W+2], addr_off[1:0]};

  assign gnt = data_req_i && !stall_i && (cnt == WS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= 4'd0;
    end else if (!data_req_i || gnt) begin
      cnt <= 4'd0;
    end else if (!stall_i && (cnt != WS)) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt && in_range && data_we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (data_be_i[n]) mem[index][8*n +: 8] <= data_wdata_i[8*n +: 8];
      end
    end
  end

  // Response data is zero unless a granted in-range load captured a word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      rvalid_q <= gnt;
      rdata_q  <= (gnt && in_range && !data_we_i) ? mem[index] : 32'd0;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_err_o    = gnt && !in_range;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign busy_o        = data_req_i || rvalid_q;

endmodule
